// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Purpose  : Shared divide type, minimum ratio and ratio clamp for clk_div_multi.
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  localparam int          c_DIV_W_DEF = 8;
  localparam int unsigned c_MIN_DIV   = 2;

  typedef logic [c_DIV_W_DEF-1:0] div_t;

  // Ratios below 2 cannot form a high and a low phase, so they are raised to 2.
  function automatic int unsigned clamp_div(input int unsigned v);
    return (v < c_MIN_DIV) ? c_MIN_DIV : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_chan
// Purpose  : One divider channel: counter, active/pending ratio, registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_chan #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clkIn,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [DIV_W-1:0] c_DEF = DIV_W'(DEFAULT_DIV);

  logic             r_run;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pdiv;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;

  logic             w_wrap;
  logic             w_restart;
  logic [DIV_W-1:0] w_cnt_inc;
  logic [DIV_W:0]   w_twice;
  logic [DIV_W-1:0] w_next_div;

  assign w_wrap     = (r_cnt == r_div - DIV_W'(1));
  assign w_restart  = !r_run || sync || w_wrap;
  assign w_cnt_inc  = r_cnt + DIV_W'(1);
  // c < ceil(D/2) is the same test as 2c < D, which avoids the rounding term.
  assign w_twice    = {w_cnt_inc, 1'b0};
  assign w_next_div = wr ? wr_val : (r_pend ? r_pdiv : r_div);

  always_ff @(posedge clkIn) begin
    if (!reset_n) begin
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_div  <= c_DEF;
      r_pdiv <= c_DEF;
      r_pend <= 1'b0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (!en) begin
      // Idle has no period boundary, so any new or waiting ratio lands now.
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
      r_div  <= w_next_div;
      r_pend <= 1'b0;
    end else if (w_restart) begin
      r_run  <= 1'b1;
      r_cnt  <= '0;
      r_clk  <= 1'b1;
      r_tick <= 1'b1;
      r_div  <= w_next_div;
      r_pend <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_inc;
      r_clk  <= (w_twice < {1'b0, r_div});
      r_tick <= 1'b0;
      if (wr) begin
        r_pdiv <= wr_val;
        r_pend <= 1'b1;
      end
    end
  end

  assign clk_out = r_clk;
  assign tick    = r_tick;
  assign pending = r_pend;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_multi
// Purpose  : NUM_OUT runtime-programmable clock dividers with tick strobes and sync.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_OUT     = 4,
  parameter  int DIV_W       = 8,
  parameter  int DEFAULT_DIV = 4,
  localparam int SEL_W       = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic               clkIn,
  input  logic               reset_n,
  input  logic [NUM_OUT-1:0] en,
  input  logic               sync,
  input  logic               div_wr,
  input  logic [SEL_W-1:0]   div_sel,
  input  logic [DIV_W-1:0]   div_val,
  output logic [NUM_OUT-1:0] clkOut,
  output logic [NUM_OUT-1:0] tick,
  output logic [NUM_OUT-1:0] pending
);

  logic [DIV_W-1:0] w_val_clamped;

  assign w_val_clamped = DIV_W'(clamp_div(32'(div_val)));

  // An out-of-range div_sel matches no index, so the write is dropped.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan
    logic w_wr;

    assign w_wr = div_wr && (div_sel == SEL_W'(i));

    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clkIn   (clkIn),
      .reset_n (reset_n),
      .en      (en[i]),
      .sync    (sync),
      .wr      (w_wr),
      .wr_val  (w_val_clamped),
      .clk_out (clkOut[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule
`default_nettype wire
